// File: rtl/proc_nic_pkg.sv
// Shared constants for the processor/network interface: register map,
// packet width and the position of the virtual-channel bit.
package proc_nic_pkg;

   localparam int NIC_DATA_W = 64;
   localparam int VC_BIT     = 0;

   localparam logic [1:0] ADDR_IBUF  = 2'b00;
   localparam logic [1:0] ADDR_ISTAT = 2'b01;
   localparam logic [1:0] ADDR_OBUF  = 2'b10;
   localparam logic [1:0] ADDR_OSTAT = 2'b11;

endpackage

// File: rtl/nic_slot.sv
// Single-entry packet buffer: data register plus full flag.
// Load wins over clear; the top never asserts both together.
module nic_slot #(
   parameter int W = 64
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic         clr,
   input  logic [0:W-1] d,
   output logic [0:W-1] q,
   output logic         full
);

   always_ff @(posedge clk) begin
      if (!reset) begin
         q    <= '0;
         full <= 1'b0;
      end else if (load) begin
         q    <= d;
         full <= 1'b1;
      end else if (clr) begin
         full <= 1'b0;
      end
   end

endmodule

// File: rtl/proc_nic.sv
// Processor-to-router network interface: one input slot filled by the router
// and drained by processor reads, one output slot filled by processor writes.
module proc_nic
   import proc_nic_pkg::*;
#(
   parameter int DATA_W = NIC_DATA_W,
   parameter int ADDR_W = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [0:ADDR_W-1] addr,
   input  logic [0:DATA_W-1] d_in,
   output logic [0:DATA_W-1] d_out,
   input  logic              nicEn,
   input  logic              nicWrEn,
   output logic              net_so,
   input  logic              net_ro,
   output logic [0:DATA_W-1] net_do,
   input  logic              polarity,
   input  logic              net_si,
   output logic              net_ri,
   input  logic [0:DATA_W-1] net_di
);

   logic              rd, wr;
   logic              in_full, out_full;
   logic              in_load, in_clr, out_load;
   logic [0:DATA_W-1] in_q, out_q;

   assign rd = nicEn & ~nicWrEn;
   assign wr = nicEn &  nicWrEn;

   // Router side: accept only into an empty slot, send only on matching VC phase.
   assign net_ri  = reset & ~in_full;
   assign in_load = net_si & net_ri;
   assign net_so  = reset & out_full & net_ro & (out_q[VC_BIT] == polarity);
   assign net_do  = out_q;

   // Processor side: flags are sampled pre-edge, so a write into a slot that is
   // draining this same cycle is dropped.
   assign in_clr   = rd & (addr == ADDR_IBUF) & in_full;
   assign out_load = wr & (addr == ADDR_OBUF) & ~out_full;

   nic_slot #(.W(DATA_W)) u_in_slot (
      .clk   (clk),
      .reset (reset),
      .load  (in_load),
      .clr   (in_clr),
      .d     (net_di),
      .q     (in_q),
      .full  (in_full)
   );

   nic_slot #(.W(DATA_W)) u_out_slot (
      .clk   (clk),
      .reset (reset),
      .load  (out_load),
      .clr   (net_so),
      .d     (d_in),
      .q     (out_q),
      .full  (out_full)
   );

   always_comb begin
      d_out = '0;
      if (rd) begin
         case (addr)
            ADDR_IBUF:  d_out = in_q;
            ADDR_ISTAT: d_out = {{(DATA_W-1){1'b0}}, in_full};
            ADDR_OBUF:  d_out = '0;
            ADDR_OSTAT: d_out = {{(DATA_W-1){1'b0}}, out_full};
            default:    d_out = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_proc_nic.sv
// Scoreboard bench for proc_nic: stimulus predicts per-cycle outputs and sent
// packets into queues; a negedge monitor pops and compares.
module tb_proc_nic;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [0:1]  addr = 2'b00;
   logic [0:63] d_in = '0;
   logic [0:63] d_out;
   logic        nicEn = 1'b0, nicWrEn = 1'b0;
   logic        net_so, net_ri;
   logic        net_ro = 1'b0, polarity = 1'b0, net_si = 1'b0;
   logic [0:63] net_do;
   logic [0:63] net_di = '0;

   int checks = 0;
   int errors = 0;
   bit started = 0;

   typedef struct {
      logic        ri;
      logic        so;
      logic [0:63] dout;
   } exp_t;

   exp_t        cyc_q[$];
   logic [0:63] pkt_q[$];

   // reference state
   bit          m_in_full, m_out_full;
   logic [0:63] m_in, m_out;

   proc_nic dut (
      .clk(clk), .reset(reset), .addr(addr), .d_in(d_in), .d_out(d_out),
      .nicEn(nicEn), .nicWrEn(nicWrEn), .net_so(net_so), .net_ro(net_ro),
      .net_do(net_do), .polarity(polarity), .net_si(net_si), .net_ri(net_ri),
      .net_di(net_di)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (started) begin
            if (cyc_q.size() == 0) begin
               chk("cycle_expectation_present", 64'd0, 64'd1);
            end else begin
               e = cyc_q.pop_front();
               chk("net_ri", {63'd0, net_ri}, {63'd0, e.ri});
               chk("net_so", {63'd0, net_so}, {63'd0, e.so});
               chk("d_out", d_out, e.dout);
            end
            if (net_so === 1'b1) begin
               if (pkt_q.size() == 0) chk("unexpected_send", 64'd1, 64'd0);
               else chk("net_do", net_do, pkt_q.pop_front());
            end
         end
      end
   end

   // Predict this cycle from the reference state, then advance it at the edge.
   task automatic step();
      exp_t        e;
      logic        rst, rd, wr, so, ri, si, en;
      logic [0:1]  a;
      logic [0:63] din, di;
      rst = reset; en = nicEn; a = addr; din = d_in; si = net_si; di = net_di;
      rd  = en && !nicWrEn;
      wr  = en && nicWrEn;
      ri  = rst && !m_in_full;
      so  = rst && m_out_full && net_ro && (m_out[0] == polarity);
      e.ri = ri;
      e.so = so;
      e.dout = '0;
      if (rd) begin
         if (a == 2'd0)      e.dout = m_in;
         else if (a == 2'd1) e.dout = m_in_full ? 64'd1 : 64'd0;
         else if (a == 2'd3) e.dout = m_out_full ? 64'd1 : 64'd0;
      end
      started = 1;
      cyc_q.push_back(e);
      if (so) pkt_q.push_back(m_out);
      @(posedge clk);
      if (!rst) begin
         m_in_full = 0; m_out_full = 0; m_in = '0; m_out = '0;
      end else begin
         if (si && ri) begin
            m_in = di; m_in_full = 1;
         end else if (rd && a == 2'd0 && m_in_full) begin
            m_in_full = 0;
         end
         if (so) m_out_full = 0;
         else if (wr && a == 2'd2 && !m_out_full) begin
            m_out = din; m_out_full = 1;
         end
      end
      #1;
   endtask

   task automatic proc(input logic en, input logic wr, input logic [1:0] a, input logic [63:0] d);
      nicEn = en; nicWrEn = wr; addr = a; d_in = d;
   endtask

   task automatic idle();
      proc(0, 0, 2'd0, 64'd0);
      net_si = 0;
   endtask

   initial begin
      @(posedge clk); #1;
      // reset for 3 cycles, then status reads
      reset = 0; idle();
      repeat (3) step();
      reset = 1; net_ro = 1; polarity = 0;
      proc(1, 0, 2'd1, 0); step();
      proc(1, 0, 2'd3, 0); step();

      // write, then send next cycle; status clears after the send
      proc(1, 1, 2'd2, 64'h0000_0000_DEAD_BEEF); step();
      proc(1, 0, 2'd3, 0); step();
      proc(1, 0, 2'd3, 0); step();

      // VC mismatch holds the packet; toggling polarity releases it
      proc(1, 1, 2'd2, 64'h8000_0000_0000_0001); step();
      proc(1, 0, 2'd3, 0); step();
      idle(); step();
      proc(1, 1, 2'd2, 64'h1111_2222_3333_4444); step();
      polarity = 1; proc(1, 1, 2'd2, 64'h5555_6666_7777_8888); step();
      proc(1, 0, 2'd3, 0); step();
      polarity = 0;

      // router fill, second packet refused, drain by read
      idle(); net_si = 1; net_di = 64'h1234_5678_9ABC_DEF0; step();
      net_di = 64'hFFFF_0000_FFFF_0000; proc(1, 0, 2'd1, 0); step();
      net_si = 0; proc(1, 0, 2'd0, 0); step();
      proc(1, 0, 2'd0, 0); step();
      proc(1, 1, 2'd0, 64'hABCD); step();

      // reset with both slots full
      net_ro = 0;
      proc(1, 1, 2'd2, 64'h0000_0000_0000_0042); net_si = 1; net_di = 64'h77; step();
      idle(); step();
      reset = 0; step();
      reset = 1; net_ro = 1; proc(1, 0, 2'd1, 0); step();
      proc(1, 0, 2'd3, 0); step();

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         reset    = ($urandom_range(0, 49) != 0);
         nicEn    = $urandom_range(0, 3) != 0;
         nicWrEn  = $urandom_range(0, 1);
         addr     = 2'($urandom_range(0, 3));
         d_in     = {$urandom, $urandom};
         net_ro   = $urandom_range(0, 3) != 0;
         polarity = $urandom_range(0, 1);
         net_si   = $urandom_range(0, 1);
         net_di   = {$urandom, $urandom};
         step();
      end
      idle(); net_ro = 0; reset = 0; step();

      chk("pending_sends", 64'(pkt_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/proc_nic.md
PROC_NIC -- requirements
Module: proc_nic

Interface
REQ-001 Parameter DATA_W, default 64, width of processor data and network packet.
REQ-002 Parameter ADDR_W, default 2, width of the NIC register address.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 reset  input  1  synchronous, active-low reset (0 = reset asserted), sampled on posedge clk.
REQ-005 addr  input  [0:1]  register select: 00 input buffer, 01 input status, 10 output buffer, 11 output status.
REQ-006 d_in  input  [0:63]  processor write data.
REQ-007 d_out  output  [0:63]  processor read data.
REQ-008 nicEn  input  1  access enable from processor.
REQ-009 nicWrEn  input  1  1 = write, 0 = read; qualified by nicEn.
REQ-010 net_so  output  1  send-out valid to router.
REQ-011 net_ro  input  1  router ready to accept.
REQ-012 net_do  output  [0:63]  packet to router.
REQ-013 polarity  input  1  router virtual-channel phase.
REQ-014 net_si  input  1  send-in valid from router.
REQ-015 net_ri  output  1  NIC ready to accept from router.
REQ-016 net_di  input  [0:63]  packet from router.

Function
REQ-017 Two single-entry buffers: input buffer (router->processor) and output buffer (processor->router), each with a full flag.
REQ-018 Packet bit 0 is the VC bit; bits [1:63] are opaque to the NIC.
REQ-019 Read (nicEn=1, nicWrEn=0), combinational: addr 00 -> input buffer; 01 -> {63'b0, in_full}; 10 -> 64'b0; 11 -> {63'b0, out_full}. Status is in bit 63.
REQ-020 When nicEn=0 or nicWrEn=1, d_out is 64'b0.
REQ-021 Read of addr 00 with in_full=1 clears in_full at the same edge; with in_full=0 it returns stale contents and changes no state.
REQ-022 Write to addr 10 with out_full=0 loads d_in into the output buffer; out_full=1 from the next edge.
REQ-023 Write to addr 10 with out_full=1 is dropped; buffer and flag are unchanged.
REQ-024 Writes to addr 00, 01 and 11 are ignored.
REQ-025 net_ri = reset & ~in_full (combinational).
REQ-026 On an edge with net_si=1 and net_ri=1, net_di is captured and in_full is set; net_si with net_ri=0 is ignored.
REQ-027 net_so = reset & out_full & net_ro & (outbuf[0] == polarity) (combinational); net_do = output buffer at all times.
REQ-028 On an edge with net_so=1, out_full clears; the next packet can be written from the following cycle (single-cycle turnaround).
REQ-029 Processor write when out_full=1 in the same cycle as net_so=1 is dropped, because the flag is sampled pre-edge.
REQ-030 Processor clear of in_full (REQ-021) and a router capture cannot coincide, because net_ri=0 while full; capture is allowed from the next cycle.
REQ-031 Latency is one clock from net_di capture to status visibility, and one clock from processor write to earliest net_so.

Reset
REQ-032 At a posedge with reset=0: in_full=0, out_full=0, both buffers 64'b0; net_so=0 and net_ri=0 while reset=0.
REQ-033 Reset mid-transfer discards any buffered packet; no net_so is issued for it afterwards.

Structure
REQ-034 A shared package holds the register address constants (ADDR_IBUF, ADDR_ISTAT, ADDR_OBUF, ADDR_OSTAT), the DATA_W value and the VC bit index.
REQ-035 One sub-module, nic_slot (data register plus full flag, with load and clear inputs), is instantiated twice.

Verification
REQ-036 Reset held low for 3 cycles, then released -> both status reads return 64'h0; net_ri=1; net_so=0.
REQ-037 Write 64'h0000_0000_DEAD_BEEF to addr 10 with polarity=0 and net_ro=1 -> net_so=1 the next cycle with net_do=64'h0000_0000_DEAD_BEEF; addr 11 reads 0 after that edge.
REQ-038 Output buffer holding 64'h8000_0000_0000_0001 with polarity=0 -> net_so stays 0; after polarity toggles to 1 -> one-cycle send; a second write issued while full -> dropped.
REQ-039 Router drives net_si=1, net_di=64'h1234_5678_9ABC_DEF0 -> net_ri falls; addr 01 reads 1; a second net_si is ignored; reading addr 00 returns the first packet; net_ri=1 the next cycle.
REQ-040 Reset driven low while both buffers are full -> the following cycle both status reads return 0, net_so=0 and no packet is emitted.
